// File: rtl/deser_pkg.sv
// Shared constants and FSM state type for the serial-to-parallel word assembler.
package deser_pkg;
  localparam int DATA_W     = 16;
  localparam int MOD_W      = 4;
  localparam int MIN_LEN    = 3;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 5;
  localparam int ENTRY_W    = DATA_W + MOD_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/deser_if.sv
// Serial input, parallel output handshake and status pulses of the deserializer.
interface deser_if;
  import deser_pkg::*;

  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              deser_ready_i;
  logic              overflow_o;
  logic              frame_err_o;

  modport master (
    output ser_data_i, ser_data_val_i, deser_ready_i,
    input  deser_data_o, deser_data_mod_o, deser_data_val_o, overflow_o, frame_err_o
  );

  modport slave (
    input  ser_data_i, ser_data_val_i, deser_ready_i,
    output deser_data_o, deser_data_mod_o, deser_data_val_o, overflow_o, frame_err_o
  );
endinterface

// File: rtl/deser_out_fifo.sv
// Small FIFO holding assembled {word, mod} entries; storage is not reset, only pointers.
module deser_out_fifo
  import deser_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is the one being written.
  always_comb begin
    wr_en    = push_i && (!full_o || pop_i);
    rd_en    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    cnt_d    = cnt_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/deserializer.sv
// MSB-first serial frame assembler with a 2-entry output buffer and overflow/fragment pulses.
module deserializer #(
  parameter int DATA_W  = deser_pkg::DATA_W,
  parameter int MIN_LEN = deser_pkg::MIN_LEN
) (
  input  logic clk_i,
  input  logic srst_i,
  deser_if.slave bus
);
  import deser_pkg::*;

  localparam int IDX_W = $clog2(DATA_W);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      bit_idx;
  logic                  push;
  logic [DATA_W-1:0]     push_word;
  logic [MOD_W-1:0]      push_mod;
  logic                  frag_err;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_empty, fifo_full, pop;

  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.ser_data_val_i) state_d = ST_SHIFT;
      ST_SHIFT: if (!bus.ser_data_val_i || count_q == CNT_W'(DATA_W - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A frame ends either on its 16th bit or on the first idle cycle after it.
  always_comb begin
    word_d    = word_q;
    count_d   = count_q;
    push      = 1'b0;
    push_word = word_q;
    push_mod  = '0;
    frag_err  = 1'b0;
    bit_idx   = CNT_W'(DATA_W - 1) - count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ser_data_val_i) begin
          word_d             = '0;
          word_d[DATA_W-1]   = bus.ser_data_i;
          count_d            = CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (bus.ser_data_val_i) begin
          word_d[bit_idx[IDX_W-1:0]] = bus.ser_data_i;
          count_d                    = count_q + CNT_W'(1);
          if (count_d == CNT_W'(DATA_W)) begin
            push      = 1'b1;
            push_word = word_d;
            push_mod  = count_d[MOD_W-1:0];
          end
        end else begin
          count_d = '0;
          if (count_q >= CNT_W'(MIN_LEN)) begin
            push      = 1'b1;
            push_word = word_q;
            push_mod  = count_q[MOD_W-1:0];
          end else begin
            frag_err = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    word_q <= word_d;
  end

  assign pop         = !fifo_empty && bus.deser_ready_i;
  assign overflow_d  = push && fifo_full && !pop;
  assign frame_err_d = frag_err;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  deser_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .push_i      (push),
    .push_data_i ({push_word, push_mod}),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Buffer storage is never cleared, so the outputs are gated by occupancy.
  assign bus.deser_data_val_o = !fifo_empty;
  assign bus.deser_data_o     = fifo_empty ? '0 : head[ENTRY_W-1:MOD_W];
  assign bus.deser_data_mod_o = fifo_empty ? '0 : head[MOD_W-1:0];
  assign bus.overflow_o       = overflow_q;
  assign bus.frame_err_o      = frame_err_q;
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: scoreboard of expected words checked at the output head.
module tb_deserializer;
  logic clk = 1'b0;
  logic srst;

  always #5 clk = ~clk;

  deser_if bus ();

  deserializer #(
    .DATA_W  (16),
    .MIN_LEN (3)
  ) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ser_data_i     = w[15-i];
      bus.ser_data_val_i = 1'b1;
      step();
    end
  endtask

  task automatic idle();
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    step();
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [3:0] m);
    exp_t e;
    e.d = d;
    e.m = m;
    sb.push_back(e);
  endtask

  task automatic check_head(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_val"}, 32'(bus.deser_data_val_o), 32'd1);
      chk({tag, "_data"}, 32'(bus.deser_data_o), 32'(e.d));
      chk({tag, "_mod"}, 32'(bus.deser_data_mod_o), 32'(e.m));
    end
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_val"}, 32'(bus.deser_data_val_o), 32'd0);
    chk({tag, "_data"}, 32'(bus.deser_data_o), 32'd0);
    chk({tag, "_mod"}, 32'(bus.deser_data_mod_o), 32'd0);
  endtask

  initial begin
    srst               = 1'b1;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    bus.deser_ready_i  = 1'b1;
    step();
    step();
    check_empty("rst");
    chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
    chk("rst_err", 32'(bus.frame_err_o), 32'd0);
    srst = 1'b0;
    idle();

    // Full 16-bit frame
    expect_word(16'hA5C3, 4'd0);
    send_bits(16'hA5C3, 16);
    check_head("a5c3");
    idle();
    check_empty("a5c3_pop");

    // 5-bit frame ends on the idle cycle
    expect_word(16'hB000, 4'd5);
    send_bits(16'hB000, 5);
    chk("b000_early", 32'(bus.deser_data_val_o), 32'd0);
    idle();
    check_head("b000");
    idle();
    check_empty("b000_pop");

    // Minimum-length frame
    expect_word(16'hE000, 4'd3);
    send_bits(16'hE000, 3);
    idle();
    check_head("min3");
    chk("min3_err", 32'(bus.frame_err_o), 32'd0);
    idle();

    // 2-bit fragment
    send_bits(16'hC000, 2);
    idle();
    chk("frag2_err", 32'(bus.frame_err_o), 32'd1);
    chk("frag2_val", 32'(bus.deser_data_val_o), 32'd0);
    idle();
    chk("frag2_err_end", 32'(bus.frame_err_o), 32'd0);

    // 1-bit fragment
    send_bits(16'h8000, 1);
    idle();
    chk("frag1_err", 32'(bus.frame_err_o), 32'd1);
    idle();

    // Overflow with consumer stalled
    bus.deser_ready_i = 1'b0;
    expect_word(16'h1111, 4'd0);
    expect_word(16'h2222, 4'd0);
    send_bits(16'h1111, 16);
    send_bits(16'h2222, 16);
    chk("ovf_not_yet", 32'(bus.overflow_o), 32'd0);
    send_bits(16'h3333, 16);
    chk("ovf_pulse", 32'(bus.overflow_o), 32'd1);
    idle();
    chk("ovf_end", 32'(bus.overflow_o), 32'd0);
    bus.deser_ready_i = 1'b1;
    check_head("ovf_1111");
    step();
    check_head("ovf_2222");
    step();
    check_empty("ovf_drain");

    // Push and pop in the same cycle while full
    bus.deser_ready_i = 1'b0;
    expect_word(16'hAAAA, 4'd0);
    expect_word(16'hBBBB, 4'd0);
    expect_word(16'hCCCC, 4'd0);
    send_bits(16'hAAAA, 16);
    send_bits(16'hBBBB, 16);
    send_bits(16'hCCCC, 15);
    check_head("pp_aaaa");
    bus.deser_ready_i  = 1'b1;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b1;
    step();
    bus.ser_data_val_i = 1'b0;
    chk("pp_ovf", 32'(bus.overflow_o), 32'd0);
    check_head("pp_bbbb");
    step();
    check_head("pp_cccc");
    step();
    check_empty("pp_drain");

    // Reset in the middle of a frame
    send_bits(16'h5A5A, 7);
    srst               = 1'b1;
    bus.ser_data_val_i = 1'b0;
    step();
    check_empty("mid_rst");
    chk("mid_rst_err", 32'(bus.frame_err_o), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow_o), 32'd0);
    srst = 1'b0;
    idle();
    chk("post_rst_err", 32'(bus.frame_err_o), 32'd0);
    check_empty("post_rst");
    expect_word(16'hFFFF, 4'd0);
    send_bits(16'hFFFF, 16);
    check_head("ffff");
    idle();

    // Gapless full frames
    expect_word(16'h0001, 4'd0);
    expect_word(16'h8000, 4'd0);
    send_bits(16'h0001, 16);
    check_head("gap_0001");
    send_bits(16'h8000, 16);
    check_head("gap_8000");
    idle();
    check_empty("gap_drain");
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
